// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: round-robin arbiter sharing two register-file write ports among four writeback requesters
// Ports: CLK/RST (sync, active-high); req_valid/req_rd/req_data per requester (0 ALU0, 1 ALU1, 2 MUL/DIV, 3 LSU);
// req_ready grant/ack; sel0/sel1 combinational mux selects; wb_en/wb_rd/wb_data registered write ports;
// conflict_cnt saturating count of cycles with an ungranted nonzero-rd request.
module wb_port_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [3:0]            req_valid,
  input  logic [4*ADDR_W-1:0]   req_rd,
  input  logic [4*DATA_W-1:0]   req_data,
  output logic [3:0]            req_ready,
  output logic [1:0]            sel0,
  output logic [1:0]            sel1,
  output logic                  wb_en0,
  output logic                  wb_en1,
  output logic [ADDR_W-1:0]     wb_rd0,
  output logic [ADDR_W-1:0]     wb_rd1,
  output logic [DATA_W-1:0]     wb_data0,
  output logic [DATA_W-1:0]     wb_data1,
  output logic [15:0]           conflict_cnt
);
  logic [ADDR_W-1:0] rd [4];
  logic [DATA_W-1:0] dat [4];
  logic [3:0] cand, rdy;
  logic [1:0] ptr, idx, g0_i, g1_i;
  logic g0_v, g1_v, skip;
  for (genvar i = 0; i < 4; i++) begin : g_unpack
    assign rd[i] = req_rd[i*ADDR_W +: ADDR_W];
    assign dat[i] = req_data[i*DATA_W +: DATA_W];
    assign cand[i] = req_valid[i] & (|rd[i]);
  end
  // x0 writes are acked without a port; candidates fill port 0 then port 1 in ptr order,
  // port 1 refusing any rd equal to port 0's so one register is never written twice.
  always_comb begin
    rdy = req_valid & ~cand;
    g0_v = 1'b0;
    g1_v = 1'b0;
    g0_i = '0;
    g1_i = '0;
    skip = 1'b0;
    idx = '0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (cand[idx]) begin
        if (!g0_v) begin
          g0_v = 1'b1;
          g0_i = idx;
          rdy[idx] = 1'b1;
        end else if (!g1_v && rd[idx] != rd[g0_i]) begin
          g1_v = 1'b1;
          g1_i = idx;
          rdy[idx] = 1'b1;
        end else begin
          skip = 1'b1;
        end
      end
    end
  end
  assign req_ready = RST ? 4'b0000 : rdy;
  assign sel0 = RST ? 2'd0 : g0_i;
  assign sel1 = RST ? 2'd0 : g1_i;
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr <= '0;
      wb_en0 <= 1'b0;
      wb_en1 <= 1'b0;
      wb_rd0 <= '0;
      wb_rd1 <= '0;
      wb_data0 <= '0;
      wb_data1 <= '0;
      conflict_cnt <= '0;
    end else begin
      ptr <= g1_v ? g1_i + 2'd1 : g0_v ? g0_i + 2'd1 : ptr;
      wb_en0 <= g0_v;
      wb_en1 <= g1_v;
      wb_rd0 <= g0_v ? rd[g0_i] : '0;
      wb_rd1 <= g1_v ? rd[g1_i] : '0;
      wb_data0 <= g0_v ? dat[g0_i] : '0;
      wb_data1 <= g1_v ? dat[g1_i] : '0;
      conflict_cnt <= conflict_cnt + 16'(skip && !(&conflict_cnt));
    end
  end
endmodule
